// File: rtl/instruction_fetch_unit.sv
// Byte-serial RISC-V instruction fetch: assembles 32-bit little-endian words and hands them to decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter int unsigned          PC_W     = 32,
  parameter logic [PC_W-1:0]      RESET_PC = PC_W'(32'h0000_0000)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [7:0]      mem_rdata,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            fault
);

  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [1:0]      idx;
  logic [1:0]      idx_inc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;

  assign idx_inc = idx + 2'd1;
  assign pc_inc  = pc + PC_W'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign;
  assign target   = redirect_pc;
  assign misalign = |redirect_pc[1:0];
`else
  // Without the trap, redirect targets are silently aligned down to a word boundary.
  assign target = redirect_pc & ~PC_W'(3);
  assign fault  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      idx        <= 2'd0;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      inst       <= 32'd0;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault      <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // Redirect flushes any partial fetch; a same-cycle byte is dropped.
      pc         <= target;
      idx        <= 2'd0;
      inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign) begin
        state   <= FAULT;
        fault   <= 1'b1;
        mem_req <= 1'b0;
      end else begin
        state    <= FETCH;
        fault    <= 1'b0;
        mem_req  <= 1'b1;
        mem_addr <= target;
      end
`else
      state    <= FETCH;
      mem_req  <= 1'b1;
      mem_addr <= target;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (mem_req && mem_rvalid) begin
            inst[{idx, 3'b000} +: 8] <= mem_rdata;
            if (idx == 2'd3) begin
              state      <= HOLD;
              idx        <= 2'd0;
              inst_valid <= 1'b1;
              inst_pc    <= pc;
              mem_req    <= 1'b0;
            end else begin
              idx      <= idx_inc;
              mem_addr <= pc + PC_W'(idx_inc);
            end
          end else begin
            // Covers the first cycle after reset; otherwise holds request during wait states.
            mem_req  <= 1'b1;
            mem_addr <= pc + PC_W'(idx);
          end
        end
        HOLD: begin
          if (inst_ready) begin
            state      <= FETCH;
            pc         <= pc_inc;
            idx        <= 2'd0;
            inst_valid <= 1'b0;
            mem_req    <= 1'b1;
            mem_addr   <= pc_inc;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        FAULT: begin
          mem_req <= 1'b0;
        end
`endif
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a queue scoreboard of expected {pc, word} pairs.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // Memory image: addi x1,x0,5 at address 0, hashed bytes elsewhere.
  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h93;
      32'd1:   return 8'h00;
      32'd2:   return 8'h50;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  assign mem_rdata = mb(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = word_at(pc);
    sb.push_back(e);
  endtask

  // One clock: pop/compare a handshake that the coming edge completes, then sample at negedge.
  task automatic cyc();
    exp_t e;
    if (rst_n && inst_valid && inst_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("inst", inst, e.word);
        chk("inst_pc", inst_pc, e.pc);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!inst_valid && n < max) begin
      cyc();
      n++;
    end
    chk("wait_valid", 32'(inst_valid), 32'd1);
  endtask

  initial begin
    clk            = 1'b0;
    rst_n          = 1'b0;
    mem_rvalid     = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // Reset state
    cyc(); cyc(); cyc();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    // Zero-wait fetch at 0: four request cycles then one valid cycle
    rst_n = 1'b1;
    push(32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_req", 32'(mem_req), 32'd1);
      chk("t1_addr", mem_addr, 32'(i));
      chk("t1_novalid", 32'(inst_valid), 32'd0);
    end
    cyc();
    chk("t1_valid", 32'(inst_valid), 32'd1);
    chk("t1_req_off", 32'(mem_req), 32'd0);
    cyc();
    chk("t1_valid_pulse", 32'(inst_valid), 32'd0);
    chk("t1_next_addr", mem_addr, 32'd4);
    chk("t1_next_req", 32'(mem_req), 32'd1);

    // Backpressure: decode stalls for 6 cycles
    inst_ready = 1'b0;
    push(32'd4);
    wait_valid(10);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t2_inst_stable", inst, word_at(32'd4));
      chk("t2_pc_stable", inst_pc, 32'd4);
      chk("t2_req_off", 32'(mem_req), 32'd0);
      chk("t2_valid_held", 32'(inst_valid), 32'd1);
    end
    inst_ready = 1'b1;
    cyc();
    chk("t2_next_addr", mem_addr, 32'd8);
    chk("t2_next_req", 32'(mem_req), 32'd1);

    // Three wait states on byte 2
    push(32'd8);
    cyc();
    cyc();
    chk("t3_addr2", mem_addr, 32'd10);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_wait_req", 32'(mem_req), 32'd1);
      chk("t3_wait_addr", mem_addr, 32'd10);
    end
    mem_rvalid = 1'b1;
    wait_valid(10);
    cyc();
    chk("t3_next_addr", mem_addr, 32'd12);

    // Redirect at idx 2 with a byte arriving the same cycle
    cyc();
    cyc();
    chk("t4_pre_addr", mem_addr, 32'd14);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    push(32'h100);
    cyc();
    redirect_valid = 1'b0;
    chk("t4_addr", mem_addr, 32'h100);
    chk("t4_req", 32'(mem_req), 32'd1);
    chk("t4_novalid", 32'(inst_valid), 32'd0);
    wait_valid(10);
    cyc();

    // PC wrap from the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC);
    cyc();
    redirect_valid = 1'b0;
    chk("t5_addr", mem_addr, 32'hFFFF_FFFC);
    wait_valid(10);
    cyc();
    chk("t5_wrap_addr", mem_addr, 32'd0);
    chk("t5_inst_kept", inst, word_at(32'hFFFF_FFFC));

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
`ifdef FETCH_MISALIGN_TRAP_EN
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_fault", 32'(fault), 32'd1);
      chk("t6_req_off", 32'(mem_req), 32'd0);
      chk("t6_novalid", 32'(inst_valid), 32'd0);
      cyc();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    push(32'h200);
    cyc();
    redirect_valid = 1'b0;
    chk("t6_fault_clr", 32'(fault), 32'd0);
    chk("t6_req", 32'(mem_req), 32'd1);
    chk("t6_addr", mem_addr, 32'h200);
`else
    push(32'h100);
    cyc();
    redirect_valid = 1'b0;
    chk("t6_addr_aligned", mem_addr, 32'h100);
    chk("t6_req", 32'(mem_req), 32'd1);
    chk("t6_fault_zero", 32'(fault), 32'd0);
`endif
    wait_valid(10);
    cyc();

    // Reset while an instruction is pending in HOLD
    inst_ready = 1'b0;
    wait_valid(10);
    rst_n = 1'b0;
    cyc();
    chk("t7_valid_clr", 32'(inst_valid), 32'd0);
    chk("t7_req", 32'(mem_req), 32'd0);
    chk("t7_addr", mem_addr, 32'd0);
    chk("t7_inst", inst, 32'd0);
    chk("t7_fault", 32'(fault), 32'd0);
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    cyc();
    chk("t7_restart_req", 32'(mem_req), 32'd1);
    chk("t7_restart_addr", mem_addr, 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
